instr_encoder_writer: RTL and testbench

//  Packs decoded instruction fields (op/funk/rd/rs/rt/iImm/jImm) back into 16-bit instruction

---
 rtl/instr_encoder_writer.sv | 168 ++++++++++++++++
 tb/tb_instr_encoder_writer.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder_writer.sv
// instr_encoder_writer
// Packs decoded instruction fields (R/I/J formats) into 16-bit words and
// writes them to consecutive instruction-memory addresses, starting at a
// base address, over a req/ack write port. Illegal tuples are dropped and
// flagged in a sticky error bit.
module instr_encoder_writer #(
    parameter int ADDR_W = 8
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        fmt,
    input  logic [3:0]        op,
    input  logic [3:0]        funk,
    input  logic [2:0]        rd,
    input  logic [2:0]        rs,
    input  logic [2:0]        rt,
    input  logic [5:0]        iImm,
    input  logic [11:0]       jImm,
    input  logic              last,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    input  logic              mem_ack,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   count
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCEPT = 2'd1,
        ST_WRITE  = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    localparam logic [1:0] FMT_R = 2'b00;
    localparam logic [1:0] FMT_I = 2'b01;
    localparam logic [1:0] FMT_J = 2'b10;

    // count stops here: one full pass over the address space
    localparam logic [ADDR_W:0] COUNT_MAX = {1'b1, {ADDR_W{1'b0}}};

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [15:0]         wdata_q, wdata_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic                err_q, err_d;
    logic                last_q, last_d;

    logic [15:0]         enc_word;
    logic                enc_legal;

    // Field packing and legality of the tuple currently on the inputs
    always_comb begin
        // NOTE: every output of a combinational block gets a default first;
        // a path that leaves one unassigned would infer a latch.
        enc_word  = '0;
        enc_legal = 1'b0;
        unique case (fmt)
            FMT_R: begin
                enc_word  = {op, rd, rs, rt, funk[2:0]};
                enc_legal = ~funk[3];
            end
            FMT_I: begin
                enc_word  = {op, rd, rs, iImm};
                enc_legal = 1'b1;
            end
            FMT_J: begin
                enc_word  = {op, jImm};
                enc_legal = 1'b1;
            end
            default: begin
                enc_word  = '0;
                enc_legal = 1'b0;
            end
        endcase
    end

    // Next-state and datapath updates; start overrides everything
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        count_d = count_q;
        err_d   = err_q;
        last_d  = last_q;

        if (start) begin
            state_d = ST_ACCEPT;
            addr_d  = base_addr;
            count_d = '0;
            err_d   = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    state_d = ST_IDLE;
                end
                ST_ACCEPT: begin
                    if (in_valid) begin
                        if (enc_legal) begin
                            wdata_d = enc_word;
                            last_d  = last;
                            state_d = ST_WRITE;
                        end else begin
                            // dropped tuple; a dropped final tuple still ends the session
                            err_d = 1'b1;
                            if (last) begin
                                state_d = ST_DONE;
                            end
                        end
                    end
                end
                ST_WRITE: begin
                    if (mem_ack) begin
                        addr_d = addr_q + ADDR_W'(1);
                        if (count_q != COUNT_MAX) begin
                            count_d = count_q + (ADDR_W+1)'(1);
                        end
                        state_d = last_q ? ST_DONE : ST_ACCEPT;
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State and datapath registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values, independent of order.
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            count_q <= count_d;
            err_q   <= err_d;
            last_q  <= last_d;
        end
    end

    // Outputs decode straight from state, so reset clears mem_we at once
    assign in_ready  = (state_q == ST_ACCEPT);
    assign mem_we    = (state_q == ST_WRITE);
    assign done      = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign err       = err_q;
    assign count     = count_q;

endmodule

// File: tb/tb_instr_encoder_writer.sv
// tb_instr_encoder_writer
// Directed plus randomized sessions. Each accepted legal tuple pushes its
// expected (address, word) into a queue; each final tuple pushes the
// expected end-of-session count/err. A monitor acting on the falling edge
// drives mem_ack and pops/compares whenever a write is accepted or done pulses.
module tb_instr_encoder_writer;

    localparam int ADDR_W = 8;
    localparam int NADDR  = 1 << ADDR_W;

    logic              clock = 1'b0;
    logic              reset_n = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [1:0]        fmt = '0;
    logic [3:0]        op = '0;
    logic [3:0]        funk = '0;
    logic [2:0]        rd = '0;
    logic [2:0]        rs = '0;
    logic [2:0]        rt = '0;
    logic [5:0]        iImm = '0;
    logic [11:0]       jImm = '0;
    logic              last = 1'b0;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_wdata;
    logic              mem_ack = 1'b0;
    logic              busy;
    logic              done;
    logic              err;
    logic [ADDR_W:0]   count;

    instr_encoder_writer #(.ADDR_W(ADDR_W)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .start     (start),
        .base_addr (base_addr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .fmt       (fmt),
        .op        (op),
        .funk      (funk),
        .rd        (rd),
        .rs        (rs),
        .rt        (rt),
        .iImm      (iImm),
        .jImm      (jImm),
        .last      (last),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .count     (count)
    );

    always #5 clock = ~clock;

    typedef struct { int addr; int word; } wr_t;
    typedef struct { int cnt;  int err;  } sess_t;

    wr_t   wr_q[$];
    sess_t done_q[$];

    int nvec  = 0;
    int nfail = 0;
    // 0 random ack, 1 always ack, 2 never ack
    int ack_mode = 0;

    // reference-model session state
    int m_addr  = 0;
    int m_count = 0;
    int m_err   = 0;

    task automatic check(input string name, input longint act, input longint exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit ref_legal(input int f, input int fk);
        return (f != 3) && !(f == 0 && fk >= 8);
    endfunction

    function automatic int ref_word(input int f, input int o, input int fk, input int d,
                                    input int s, input int t, input int ii, input int jj);
        case (f)
            0:       return o * 4096 + d * 512 + s * 64 + t * 8 + (fk % 8);
            1:       return o * 4096 + d * 512 + s * 64 + ii;
            default: return o * 4096 + jj;
        endcase
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_start(input int b);
        base_addr = b[ADDR_W-1:0];
        start     = 1'b1;
        tick();
        start   = 1'b0;
        m_addr  = b % NADDR;
        m_count = 0;
        m_err   = 0;
    endtask

    task automatic send(input int f, input int o, input int fk, input int d, input int s,
                        input int t, input int ii, input int jj, input bit l);
        int n = 0;
        fmt  = f[1:0];
        op   = o[3:0];
        funk = fk[3:0];
        rd   = d[2:0];
        rs   = s[2:0];
        rt   = t[2:0];
        iImm = ii[5:0];
        jImm = jj[11:0];
        last = l;
        in_valid = 1'b1;
        while (!in_ready && n < 100) begin
            tick();
            n++;
        end
        if (!in_ready) begin
            check("in_ready_timeout", in_ready, 1);
            in_valid = 1'b0;
            return;
        end
        if (ref_legal(f, fk)) begin
            wr_q.push_back('{m_addr, ref_word(f, o, fk, d, s, t, ii, jj)});
            m_addr  = (m_addr + 1) % NADDR;
            m_count = (m_count < NADDR) ? m_count + 1 : NADDR;
        end else begin
            m_err = 1;
        end
        if (l) done_q.push_back('{m_count, m_err});
        tick();
        in_valid = 1'b0;
    endtask

    task automatic send_random(input bit l, input bit legal_only);
        int sel = $urandom_range(0, 19);
        int f   = (sel < 6) ? 0 : (sel < 12) ? 1 : (sel < 17) ? 2 : 3;
        int fk  = $urandom_range(0, 9);
        if (legal_only) begin
            f  = $urandom_range(0, 2);
            fk = $urandom_range(0, 7);
        end
        send(f, $urandom_range(0, 15), fk, $urandom_range(0, 7), $urandom_range(0, 7),
             $urandom_range(0, 7), $urandom_range(0, 63), $urandom_range(0, 4095), l);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 500) begin
            tick();
            n++;
        end
        if (busy) check("idle_timeout", busy, 0);
    endtask

    // Monitor: drives mem_ack and scores accepted writes and done pulses
    initial begin
        wr_t   e;
        sess_t s;
        forever begin
            @(negedge clock);
            if (!reset_n) begin
                mem_ack = 1'b0;
            end else begin
                case (ack_mode)
                    0:       mem_ack = ($urandom_range(0, 2) != 0);
                    1:       mem_ack = 1'b1;
                    default: mem_ack = 1'b0;
                endcase
                if (mem_we && mem_ack) begin
                    if (wr_q.size() == 0) begin
                        check("unexpected_write", 1, 0);
                    end else begin
                        e = wr_q.pop_front();
                        check("wr_addr", mem_addr, e.addr);
                        check("wr_data", mem_wdata, e.word);
                    end
                end
                if (done) begin
                    if (done_q.size() == 0) begin
                        check("unexpected_done", 1, 0);
                    end else begin
                        s = done_q.pop_front();
                        check("done_count", count, s.cnt);
                        check("done_err", err, s.err);
                    end
                end
            end
        end
    end

    initial begin
        // reset state
        repeat (3) tick();
        check("rst_in_ready", in_ready, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_count", count, 0);
        check("rst_err", err, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        reset_n = 1'b1;
        tick();
        check("idle_in_ready", in_ready, 0);

        // R-type single word
        ack_mode = 0;
        do_start(8'h10);
        send(0, 4'b1111, 4'b0111, 3'b000, 3'b111, 3'b000, 0, 0, 1'b1);
        check("t1_mem_we", mem_we, 1);
        check("t1_addr", mem_addr, 8'h10);
        check("t1_wdata", mem_wdata, 16'hF1C7);
        wait_idle();
        check("t1_count", count, 1);

        // I then J back to back
        do_start(8'h20);
        send(1, 4'b0010, 0, 3'b011, 3'b001, 0, 6'b101010, 0, 1'b0);
        send(2, 4'b1000, 0, 0, 0, 0, 0, 12'hABC, 1'b1);
        wait_idle();
        check("t2_count", count, 2);
        check("t2_last_addr_adv", mem_addr, 8'h22);

        // ack stall: five cycles with ack low, everything held
        ack_mode = 2;
        do_start(8'h30);
        send(1, 4'h5, 0, 3'd2, 3'd6, 0, 6'h15, 0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            check("t3_we_held", mem_we, 1);
            check("t3_addr_held", mem_addr, 8'h30);
            check("t3_wdata_held", mem_wdata, 16'h5595);
            check("t3_in_ready_low", in_ready, 0);
            tick();
        end
        ack_mode = 1;
        wait_idle();
        check("t3_count", count, 1);
        check("t3_addr_once", mem_addr, 8'h31);

        // illegal tuples dropped, err sticky until next start
        ack_mode = 0;
        do_start(8'h40);
        send(3, 4'h7, 0, 1, 2, 3, 4, 5, 1'b0);
        send(0, 4'h7, 4'b1000, 1, 2, 3, 0, 0, 1'b0);
        check("t4_err", err, 1);
        check("t4_no_we", mem_we, 0);
        check("t4_count0", count, 0);
        send(2, 4'h3, 0, 0, 0, 0, 0, 12'h123, 1'b1);
        wait_idle();
        do_start(8'h41);
        check("t4_err_cleared", err, 0);
        send(3, 4'h1, 0, 0, 0, 0, 0, 0, 1'b1);
        wait_idle();

        // address wrap
        do_start(8'hFF);
        send_random(1'b0, 1'b1);
        send_random(1'b1, 1'b1);
        wait_idle();
        check("t5_count", count, 2);

        // abort by start mid-write
        ack_mode = 2;
        do_start(8'h50);
        send(1, 4'h9, 0, 1, 1, 0, 6'h3F, 0, 1'b0);
        check("t6_in_write", mem_we, 1);
        do_start(8'h60);
        wr_q.delete();
        check("t6_we_dropped", mem_we, 0);
        check("t6_new_base", mem_addr, 8'h60);
        check("t6_count_clr", count, 0);
        check("t6_accept", in_ready, 1);
        ack_mode = 0;
        send_random(1'b1, 1'b1);
        wait_idle();

        // asynchronous reset mid-write
        ack_mode = 2;
        do_start(8'h70);
        send(2, 4'hC, 0, 0, 0, 0, 0, 12'hFED, 1'b1);
        #2 reset_n = 1'b0;
        #1;
        check("t6_rst_we", mem_we, 0);
        check("t6_rst_addr", mem_addr, 0);
        check("t6_rst_wdata", mem_wdata, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_in_ready", in_ready, 0);
        check("t6_rst_count", count, 0);
        wr_q.delete();
        done_q.delete();
        tick();
        reset_n = 1'b1;
        tick();

        // randomized sessions
        ack_mode = 0;
        for (int s = 0; s < 30; s++) begin
            int ntup = $urandom_range(1, 8);
            do_start($urandom_range(0, NADDR - 1));
            for (int k = 0; k < ntup; k++) begin
                repeat ($urandom_range(0, 2)) tick();
                send_random(k == ntup - 1, 1'b0);
            end
            wait_idle();
        end

        // count saturation across more than a full address space
        ack_mode = 1;
        do_start(8'h80);
        for (int k = 0; k < NADDR + 4; k++) begin
            send_random(k == NADDR + 3, 1'b1);
        end
        wait_idle();
        check("sat_count", count, NADDR);
        check("sat_addr_wrapped", mem_addr, 8'h84);

        repeat (2) tick();
        check("wr_q_drained", wr_q.size(), 0);
        check("done_q_drained", done_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
